// File: rtl/irf_pkg.sv
// Shared definitions for the integer register-file hazard / forwarding controller.
//   - Bypass select codes driven onto mux3_sel / mux4_sel.
//   - Hardwired-zero register index.
//   - Scoreboard geometry and the per-stage entry type.
//   - stage_sel(): maps a scoreboard index (0 = S3 .. 3 = S6) to its bypass code.
package irf_pkg;

  // Tracked stages S3..S6. The scoreboard index 0 is S3 (youngest).
  localparam int unsigned STAGES = 4;

  // Register that always reads as zero; it is never tracked or forwarded.
  localparam logic [4:0] ZERO_REG = 5'd31;

  // Bypass select codes. Codes 5..7 are never driven.
  localparam logic [2:0] SEL_RF    = 3'd0;  // register file
  localparam logic [2:0] SEL_IBOX3 = 3'd1;  // ibox_result3 (S3)
  localparam logic [2:0] SEL_IBOX4 = 3'd2;  // ibox_result4 (S4)
  localparam logic [2:0] SEL_MEM   = 3'd3;  // mem_out      (S5)
  localparam logic [2:0] SEL_MREG  = 3'd4;  // m_reg_out    (S6)

  // Load data exists only from S5 onwards; a load match at a lower index is a hazard.
  localparam int LOAD_READY_IDX = 2;

  // Number of youngest stages (S3, S4) killed by a flush as they shift forward.
  localparam int FLUSH_DEPTH = 2;

  // One scoreboard entry: an in-flight instruction that will write dest.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       load;
  } sb_entry_t;

  localparam int unsigned ENTRY_W = $bits(sb_entry_t);

  // Bypass code for the stage holding a match at scoreboard index idx.
  function automatic logic [2:0] stage_sel(input int idx);
    logic [2:0] sel;
    case (idx)
      0:       sel = SEL_IBOX3;
      1:       sel = SEL_IBOX4;
      2:       sel = SEL_MEM;
      default: sel = SEL_MREG;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/irf_src_match.sv
// Per-source forwarding priority encoder.
// Finds the youngest in-flight writer of one source register and returns the
// bypass select for it, or flags a load-use hazard when that youngest writer is
// a load whose data is not yet available.
// Ports:
//   uses        in   source operand is actually read
//   src         in   source register index
//   sb_flat     in   scoreboard entries S3..S6 packed, S3 in the low bits
//   sel         out  bypass select (SEL_RF when no match or on a hazard)
//   load_hazard out  youngest match is a load still in S3/S4
module irf_src_match
  import irf_pkg::*;
(
  input  logic                        uses,
  input  logic [4:0]                  src,
  input  logic [STAGES*ENTRY_W-1:0]   sb_flat,
  output logic [2:0]                  sel,
  output logic                        load_hazard
);

  sb_entry_t entries [STAGES];

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      entries[i] = sb_entry_t'(sb_flat[i*ENTRY_W +: ENTRY_W]);
    end
  end

  // Walk oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    sel         = SEL_RF;
    load_hazard = 1'b0;
    if (uses && (src != ZERO_REG)) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (entries[i].valid && (entries[i].dest == src)) begin
          if (entries[i].load && (i < LOAD_READY_IDX)) begin
            // Data not ready: select is don't-care, drive the register file.
            sel         = SEL_RF;
            load_hazard = 1'b1;
          end else begin
            sel         = stage_sel(i);
            load_hazard = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/irf_hazard_ctrl.sv
// Hazard and forwarding controller for the integer register-file datapath.
// Keeps a four-entry scoreboard of in-flight destination registers (S3..S6),
// derives the operand bypass selects and the load-use stall combinationally
// from the issuing instruction, and raises the register-file write strobe one
// cycle after an instruction leaves S6.
// Ports:
//   clk            in   clock, all state on posedge
//   reset          in   synchronous active-high reset
//   issue_valid    in   instruction presented at issue
//   issue_ra/rb    in   source register indices
//   issue_uses_ra/rb in source actually read
//   issue_dest     in   destination register index
//   issue_writes   in   instruction writes issue_dest
//   issue_is_load  in   result comes from memory (ready at S5)
//   flush          in   kill S3, S4 and the issuing instruction
//   mux3_sel       out  operand A bypass select (comb.)
//   mux4_sel       out  operand B bypass select (comb.)
//   stall          out  hold issue, bubble into S3 (comb.)
//   write_en       out  register-file write strobe (registered)
//   write_addr     out  register-file write index (registered, holds when idle)
module irf_hazard_ctrl
  import irf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [4:0] issue_ra,
  input  logic [4:0] issue_rb,
  input  logic       issue_uses_ra,
  input  logic       issue_uses_rb,
  input  logic [4:0] issue_dest,
  input  logic       issue_writes,
  input  logic       issue_is_load,
  input  logic       flush,
  output logic [2:0] mux3_sel,
  output logic [2:0] mux4_sel,
  output logic       stall,
  output logic       write_en,
  output logic [4:0] write_addr
);

  sb_entry_t sb_q [STAGES];
  sb_entry_t sb_d [STAGES];

  logic [STAGES*ENTRY_W-1:0] sb_flat;

  logic       hazard_a;
  logic       hazard_b;
  logic       write_en_q;
  logic       write_en_d;
  logic [4:0] write_addr_q;
  logic [4:0] write_addr_d;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      sb_flat[i*ENTRY_W +: ENTRY_W] = sb_q[i];
    end
  end

  irf_src_match u_match_a (
    .uses        (issue_uses_ra),
    .src         (issue_ra),
    .sb_flat     (sb_flat),
    .sel         (mux3_sel),
    .load_hazard (hazard_a)
  );

  irf_src_match u_match_b (
    .uses        (issue_uses_rb),
    .src         (issue_rb),
    .sb_flat     (sb_flat),
    .sel         (mux4_sel),
    .load_hazard (hazard_b)
  );

  // A flushed issue never enters the pipe, so it has nothing to wait for.
  assign stall = issue_valid & ~flush & (hazard_a | hazard_b);

  // Scoreboard shift. A stalled or flushed issue becomes a bubble in S3.
  always_comb begin
    sb_d[0]       = '0;
    sb_d[0].valid = issue_valid & issue_writes & ~stall & ~flush &
                    (issue_dest != ZERO_REG);
    if (sb_d[0].valid) begin
      sb_d[0].dest = issue_dest;
      sb_d[0].load = issue_is_load;
    end
    for (int i = 1; i < STAGES; i++) begin
      sb_d[i] = sb_q[i-1];
      // S3 and S4 occupants die on flush as they move into S4 and S5.
      if (i <= FLUSH_DEPTH) begin
        sb_d[i].valid = sb_q[i-1].valid & ~flush;
      end
    end
  end

  // Retire: whatever sits in S6 this cycle is written next cycle.
  always_comb begin
    write_en_d   = sb_q[STAGES-1].valid;
    write_addr_d = sb_q[STAGES-1].valid ? sb_q[STAGES-1].dest : write_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        sb_q[i] <= '0;
      end
      write_en_q   <= 1'b0;
      write_addr_q <= 5'd0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sb_q[i] <= sb_d[i];
      end
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;

  // Select codes above SEL_MREG are never legal.
  sel_range_a: assert property (@(posedge clk) disable iff (reset) mux3_sel <= SEL_MREG);
  sel_range_b: assert property (@(posedge clk) disable iff (reset) mux4_sel <= SEL_MREG);
  stall_qual:  assert property (@(posedge clk) disable iff (reset)
                                stall |-> (issue_valid && !flush));

endmodule

// File: tb/tb_irf_hazard_ctrl.sv
// Self-checking bench for irf_hazard_ctrl. A list of in-flight instructions,
// each stamped with the cycle it was accepted, predicts every output each cycle;
// directed literal checks pin the expected behaviour at chosen points.
module tb_irf_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_ra;
  logic [4:0] issue_rb;
  logic       issue_uses_ra;
  logic       issue_uses_rb;
  logic [4:0] issue_dest;
  logic       issue_writes;
  logic       issue_is_load;
  logic       flush;
  logic [2:0] mux3_sel;
  logic [2:0] mux4_sel;
  logic       stall;
  logic       write_en;
  logic [4:0] write_addr;

  irf_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ra      (issue_ra),
    .issue_rb      (issue_rb),
    .issue_uses_ra (issue_uses_ra),
    .issue_uses_rb (issue_uses_rb),
    .issue_dest    (issue_dest),
    .issue_writes  (issue_writes),
    .issue_is_load (issue_is_load),
    .flush         (flush),
    .mux3_sel      (mux3_sel),
    .mux4_sel      (mux4_sel),
    .stall         (stall),
    .write_en      (write_en),
    .write_addr    (write_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [4:0] dest;
    bit         load;
  } rec_t;

  rec_t       q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic       ewe = 1'b0;
  logic [4:0] ewa = 5'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Youngest in-flight writer of src; ages 1..4 correspond to S3..S6.
  task automatic src_model(input logic uses, input logic [4:0] src,
                           output logic [2:0] sel, output bit hz);
    int best;
    best = 0;
    sel  = 3'd0;
    hz   = 1'b0;
    if (uses && src != 5'd31) begin
      foreach (q[i]) begin
        int age;
        age = cyc - q[i].at;
        if (age >= 1 && age <= 4 && q[i].dest == src && (best == 0 || age < best)) begin
          best = age;
          hz   = q[i].load && age <= 2;
        end
      end
    end
    if (best != 0 && !hz) sel = 3'(best);
  endtask

  // Compare every output against the model, then advance the model by one edge.
  task automatic model_cycle();
    logic [2:0] es_a;
    logic [2:0] es_b;
    bit         hz_a;
    bit         hz_b;
    logic       e_stall;
    rec_t       nq[$];
    rec_t       r;
    src_model(issue_uses_ra, issue_ra, es_a, hz_a);
    src_model(issue_uses_rb, issue_rb, es_b, hz_b);
    e_stall = issue_valid && !flush && (hz_a || hz_b);
    chk("cyc_mux3_sel", 8'(mux3_sel), 8'(es_a));
    chk("cyc_mux4_sel", 8'(mux4_sel), 8'(es_b));
    chk("cyc_stall", 8'(stall), 8'(e_stall));
    chk("cyc_write_en", 8'(write_en), 8'(ewe));
    chk("cyc_write_addr", 8'(write_addr), 8'(ewa));
    if (reset) begin
      q.delete();
      ewe = 1'b0;
      ewa = 5'd0;
    end else begin
      ewe = 1'b0;
      foreach (q[i]) begin
        int age;
        age = cyc - q[i].at;
        if (age == 4) begin
          ewe = 1'b1;
          ewa = q[i].dest;
        end else if (!(flush && age <= 2)) begin
          nq.push_back(q[i]);
        end
      end
      q = nq;
      if (issue_valid && issue_writes && !e_stall && !flush && issue_dest != 5'd31) begin
        r.at   = cyc;
        r.dest = issue_dest;
        r.load = issue_is_load;
        q.push_back(r);
      end
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [4:0] ra, input logic ura,
                      input logic [4:0] rb, input logic urb, input logic [4:0] d,
                      input logic w, input logic ld, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    issue_valid   = v;
    issue_ra      = ra;
    issue_uses_ra = ura;
    issue_rb      = rb;
    issue_uses_rb = urb;
    issue_dest    = d;
    issue_writes  = w;
    issue_is_load = ld;
    flush         = fl;
    reset         = rst;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [4:0] d, input logic ld);
    step(1, 0, 0, 0, 0, d, 1, ld, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_ra = 5'd0; issue_rb = 5'd0;
    issue_uses_ra = 1'b0; issue_uses_rb = 1'b0; issue_dest = 5'd0;
    issue_writes = 1'b0; issue_is_load = 1'b0; flush = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 4, 1, 6, 1, 0, 0, 0, 0, 0);
    chk("reset_mux3", 8'(mux3_sel), 8'd0);
    chk("reset_mux4", 8'(mux4_sel), 8'd0);
    chk("reset_stall", 8'(stall), 8'd0);
    chk("reset_we", 8'(write_en), 8'd0);
    chk("reset_wa", 8'(write_addr), 8'd0);

    // ALU back-to-back and retire timing.
    wr(3, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_b2b_sel", 8'(mux3_sel), 8'd1);
    chk("alu_b2b_stall", 8'(stall), 8'd0);
    repeat (4) idle();
    chk("alu_retire_we", 8'(write_en), 8'd1);
    chk("alu_retire_wa", 8'(write_addr), 8'd3);

    // Producer distance sweep on operand B.
    for (int d = 1; d <= 5; d++) begin
      wr(5, 0);
      repeat (d - 1) idle();
      step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      chk($sformatf("dist%0d_sel", d), 8'(mux4_sel), (d < 5) ? 8'(d) : 8'd0);
      repeat (5) idle();
    end

    // Load-use, consumer right behind the load: two stall cycles.
    wr(7, 1);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    chk("ld_use_stall1", 8'(stall), 8'd1);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    chk("ld_use_stall2", 8'(stall), 8'd1);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    chk("ld_use_go", 8'(stall), 8'd0);
    chk("ld_use_sel", 8'(mux4_sel), 8'd3);
    repeat (5) idle();

    // Load-use with one instruction between: one stall cycle.
    wr(8, 1);
    wr(9, 0);
    step(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_gap_stall", 8'(stall), 8'd1);
    step(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_gap_go", 8'(stall), 8'd0);
    chk("ld_gap_sel", 8'(mux3_sel), 8'd3);
    repeat (5) idle();

    // Youngest writer wins.
    wr(2, 0);
    idle();
    wr(2, 0);
    step(1, 2, 1, 2, 1, 0, 0, 0, 0, 0);
    chk("prio_sel_a", 8'(mux3_sel), 8'd1);
    chk("prio_sel_b", 8'(mux4_sel), 8'd1);
    repeat (5) idle();

    // Zero register is never tracked.
    wr(31, 0);
    step(1, 31, 1, 31, 1, 0, 0, 0, 0, 0);
    chk("zero_sel_a", 8'(mux3_sel), 8'd0);
    chk("zero_sel_b", 8'(mux4_sel), 8'd0);
    repeat (4) idle();
    chk("zero_no_we", 8'(write_en), 8'd0);
    repeat (2) idle();

    // Flush kills S3, S4 and the issuing instruction; S5/S6 still retire.
    wr(10, 0);
    wr(11, 0);
    wr(12, 0);
    wr(13, 0);
    step(1, 0, 0, 0, 0, 14, 1, 0, 1, 0);
    idle();
    chk("flush_s6_we", 8'(write_en), 8'd1);
    chk("flush_s6_wa", 8'(write_addr), 8'd10);
    idle();
    chk("flush_s5_we", 8'(write_en), 8'd1);
    chk("flush_s5_wa", 8'(write_addr), 8'd11);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("flush_killed_we", 8'(write_en), 8'd0);
      chk("flush_hold_wa", 8'(write_addr), 8'd11);
    end

    // Flush with a pending load hazard: no stall, and the load is gone.
    wr(20, 1);
    step(1, 0, 0, 20, 1, 0, 0, 0, 1, 0);
    chk("flush_stall", 8'(stall), 8'd0);
    step(1, 0, 0, 20, 1, 0, 0, 0, 0, 0);
    chk("flush_ld_gone_stall", 8'(stall), 8'd0);
    chk("flush_ld_gone_sel", 8'(mux4_sel), 8'd0);
    repeat (5) idle();

    // Reset with all four stages valid.
    wr(1, 0);
    wr(2, 0);
    wr(3, 0);
    wr(4, 0);
    step(1, 1, 1, 4, 1, 0, 0, 0, 0, 1);
    chk("rst_pre_sel_a", 8'(mux3_sel), 8'd4);
    chk("rst_pre_sel_b", 8'(mux4_sel), 8'd1);
    step(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    chk("rst_sel_a", 8'(mux3_sel), 8'd0);
    chk("rst_sel_b", 8'(mux4_sel), 8'd0);
    chk("rst_we", 8'(write_en), 8'd0);
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("rst_no_we", 8'(write_en), 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
